wb_stage: RTL

- Write-back stage feeding the register file's single write port (wen/waddr/wdata).
- Accepts completed instructions from execute via valid/ready. ALU results are written directly; loads wait for a memory read-data handshake, then are byte/half extracted and sign/zero extended.
- Exposes pending-destination info for the decode-stage hazard check.

---
 rtl/wb_stage_if.sv | 36 +++
 rtl/wb_stage.sv | 114 +++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Bundle of the write-back stage's execute, memory read-data and register-file signals.
// The master side is whoever drives the stage (execute/memory); the slave side is the stage.
interface wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_waddr;
  logic [DATA_WIDTH-1:0] in_result;
  logic                  in_is_load;
  logic [1:0]            in_load_size;
  logic                  in_load_unsigned;
  logic [1:0]            in_addr_lo;
  logic                  mem_rdata_valid;
  logic                  mem_rdata_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] pending_waddr;
  logic                  retire;

  modport master (
    output in_valid, in_waddr, in_result, in_is_load, in_load_size, in_load_unsigned,
           in_addr_lo, mem_rdata_valid, mem_rdata,
    input  in_ready, mem_rdata_ready, wen, waddr, wdata, pending, pending_waddr, retire
  );

  modport slave (
    input  in_valid, in_waddr, in_result, in_is_load, in_load_size, in_load_unsigned,
           in_addr_lo, mem_rdata_valid, mem_rdata,
    output in_ready, mem_rdata_ready, wen, waddr, wdata, pending, pending_waddr, retire
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly, holds loads until read data returns,
// then extracts/extends the addressed byte or half and drives the register-file write port.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_stage_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t                state, state_next;
  logic                  in_ready_c;
  logic                  mem_ready_c;
  logic                  accept;
  logic                  mem_xfer;
  logic [ADDR_WIDTH-1:0] next_dest;

  logic [ADDR_WIDTH-1:0] cap_waddr;
  logic [1:0]            cap_size;
  logic                  cap_unsigned;
  logic [1:0]            cap_addr_lo;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  wen_q;
  logic                  retire_q;

  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            addr_lo,
    input logic                  is_unsigned
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    b = word[8*addr_lo +: 8];
    h = word[16*addr_lo[1] +: 16];
    case (size)
      2'b00:   res = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, b}  : {{(DATA_WIDTH-8){b[7]}}, b};
      2'b01:   res = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign accept    = bus.in_valid && in_ready_c;
  assign mem_xfer  = bus.mem_rdata_valid && mem_ready_c;
  assign next_dest = accept ? bus.in_waddr : cap_waddr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) state_next = bus.in_is_load ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: begin
        if (bus.mem_rdata_valid) state_next = WRITE;
      end
      WRITE: begin
        if (bus.in_valid) state_next = bus.in_is_load ? WAIT_MEM : WRITE;
        else              state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c        = (state != WAIT_MEM);
    mem_ready_c       = (state == WAIT_MEM);
    bus.in_ready      = in_ready_c;
    bus.mem_rdata_ready = mem_ready_c;
    bus.pending       = (state == WAIT_MEM);
    bus.pending_waddr = (state == WAIT_MEM) ? cap_waddr : '0;
    bus.wen           = wen_q;
    bus.retire        = retire_q;
    bus.waddr         = cap_waddr;
    bus.wdata         = cap_data;
  end

  // Write strobes are registered alongside the data they qualify; r0 writes retire but never strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wen_q        <= 1'b0;
      retire_q     <= 1'b0;
      cap_waddr    <= '0;
      cap_size     <= '0;
      cap_unsigned <= 1'b0;
      cap_addr_lo  <= '0;
      cap_data     <= '0;
    end else begin
      retire_q <= (state_next == WRITE);
      wen_q    <= (state_next == WRITE) && (next_dest != '0);
      if (accept) begin
        cap_waddr    <= bus.in_waddr;
        cap_size     <= bus.in_load_size;
        cap_unsigned <= bus.in_load_unsigned;
        cap_addr_lo  <= bus.in_addr_lo;
        if (!bus.in_is_load) cap_data <= bus.in_result;
      end else if (mem_xfer) begin
        cap_data <= load_extract(bus.mem_rdata, cap_size, cap_addr_lo, cap_unsigned);
      end
    end
  end

endmodule
